flash_access_sequencer: RTL and testbench
=========================================

FLASH_ACCESS_SEQUENCER -- requirements
Module: flash_access_sequencer

Interface
REQ-001 SHALL have parameter NRWW_START, default 14'h3800, first word address of the NRWW section (row 224).
REQ-002 SHALL have parameter ERASE_CYCLES, default 16, page-erase duration in clk cycles (range 2..65535).
REQ-003 SHALL have parameter PROG_CYCLES, default 16, page-write duration in clk cycles (range 2..65535).
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 nrst  in  1  reset, asynchronous assert, active-low.
REQ-006 fetch_req  in  1 / fetch_adr  in  14  CPU instruction fetch request and word address (PC).
REQ-007 fetch_gnt  out  1 / fetch_valid  out  1 / fetch_data  out  16  grant, data-valid strobe and instruction word.
REQ-008 lpm_req  in  1 / lpm_adr  in  15  LPM byte read request and byte address (bit 0 = high byte).
REQ-009 lpm_gnt  out  1 / lpm_valid  out  1 / lpm_data  out  8  grant, valid strobe and read byte.
REQ-010 spm_req  in  1 / spm_op  in  2 / spm_adr  in  15 / spm_data  in  16  self-programming request; op 00 = buffer fill, 01 = page erase, 10 = page write, 11 = reserved.
REQ-011 spm_gnt  out  1 / spm_done  out  1  SPM accepted, SPM completed (1-cycle pulse).
REQ-012 mem_rd, mem_fill, mem_erase, mem_prog  out  1 each  memory array strobes.
REQ-013 mem_adr  out  15 / mem_wdata  out  16 / mem_rdata  in  16  array byte address, write data, read word (registered by array, valid cycle after mem_rd).
REQ-014 rww_busy  out  1  RWW section erase/write in progress.

Function
REQ-015 SHALL implement states IDLE, READ, FILL, ERASE, PROG.
REQ-016 In IDLE, arbitration priority SHALL be spm_req > lpm_req > fetch_req; exactly one grant per cycle, same cycle as request.
REQ-017 Grant to fetch/LPM SHALL assert mem_rd with mem_adr = {fetch_adr,1'b0} or {lpm_adr[14:1],1'b0}, enter READ.
REQ-018 READ SHALL last exactly one cycle: fetch_valid or lpm_valid pulses with data from mem_rdata, then IDLE; read latency = 1 cycle from grant.
REQ-019 lpm_data SHALL be mem_rdata[15:8] when lpm_adr[0]=1, else mem_rdata[7:0].
REQ-020 Grant to SPM op 00 SHALL pulse mem_fill one cycle with mem_wdata = spm_data, spm_done next cycle (FILL), return to IDLE.
REQ-021 Grant to op 01/10 SHALL hold mem_erase/mem_prog high for exactly ERASE_CYCLES/PROG_CYCLES cycles using a 16-bit down-counter, pulse spm_done on the cycle after the counter reaches zero, then IDLE.
REQ-022 Erase/write target page SHALL be spm_adr[14:7]; mem_adr SHALL hold {spm_adr[14:7],7'b0} for the whole operation.
REQ-023 Reserved op 11 SHALL be granted and pulse spm_done next cycle with no array strobe.
REQ-024 rww_busy SHALL be high during ERASE/PROG when target word address < NRWW_START.
REQ-025 During ERASE/PROG, lpm_req and spm_req SHALL be ignored (no grant) until return to IDLE.
REQ-026 During ERASE/PROG, fetch to the section under erase/write SHALL stall (fetch_gnt low); see REQ-033 for the other section.
REQ-027 Address NRWW_START-1 SHALL be RWW, NRWW_START SHALL be NRWW (boundary inclusive on NRWW).
REQ-028 A request deasserted before grant SHALL be dropped without side effect; requests are not queued.

Reset
REQ-029 nrst low SHALL asynchronously force state IDLE, counter 0, and all outputs 0 (fetch_data, lpm_data, mem_adr, mem_wdata = 0).
REQ-030 Reset during ERASE/PROG SHALL drop mem_erase/mem_prog immediately with no spm_done.
REQ-031 First grant SHALL be possible on the first rising clk edge after nrst deasserts.

Configuration
REQ-032 Macro FLASH_SEQ_RWW_EN SHALL select read-while-write support.
REQ-033 With FLASH_SEQ_RWW_EN defined: while an RWW page is erased/written, fetches to addresses >= NRWW_START SHALL be granted as in REQ-017/018 concurrently (mem_rd with erase/prog strobe); fetches < NRWW_START stall.
REQ-034 Without it: all fetches SHALL stall during any ERASE/PROG; rww_busy still reflects REQ-024.

Verification
REQ-035 Fetch 14'h0041, array word 16'h1234 -> fetch_gnt cycle N, fetch_valid and fetch_data=16'h1234 cycle N+1.
REQ-036 lpm_req and fetch_req same cycle, lpm_adr=15'h0083, word 16'h1234 -> lpm_gnt only, lpm_data=8'h12; fetch granted the cycle after.
REQ-037 SPM op 01 spm_adr=15'h0080, default params -> mem_erase high 16 cycles, rww_busy high, spm_done pulse once; with macro, fetch 14'h3840 returns 16'h6699 mid-erase, fetch 14'h0041 stalls.
REQ-038 Same as REQ-037 without macro -> fetch 14'h3840 stalls until after spm_done.
REQ-039 SPM op 10 spm_adr=15'h7000 -> rww_busy low, all fetches stall for 16 cycles in both builds.
REQ-040 nrst low at cycle 5 of PROG -> mem_prog 0 asynchronously, no spm_done, IDLE after release.

Source files
------------

// File: rtl/flash_access_sequencer.sv
// Flash access sequencer: arbitrates instruction fetch, LPM byte reads and SPM fill/erase/write onto one array port.
// Optional read-while-write (NRWW fetches during an RWW erase/write) is enabled by defining FLASH_SEQ_RWW_EN.
module flash_access_sequencer #(
  parameter logic [13:0] NRWW_START   = 14'h3800,
  parameter int unsigned ERASE_CYCLES = 16,
  parameter int unsigned PROG_CYCLES  = 16
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        fetch_req,
  input  logic [13:0] fetch_adr,
  output logic        fetch_gnt,
  output logic        fetch_valid,
  output logic [15:0] fetch_data,
  input  logic        lpm_req,
  input  logic [14:0] lpm_adr,
  output logic        lpm_gnt,
  output logic        lpm_valid,
  output logic [7:0]  lpm_data,
  input  logic        spm_req,
  input  logic [1:0]  spm_op,
  input  logic [14:0] spm_adr,
  input  logic [15:0] spm_data,
  output logic        spm_gnt,
  output logic        spm_done,
  output logic        mem_rd,
  output logic        mem_fill,
  output logic        mem_erase,
  output logic        mem_prog,
  output logic [14:0] mem_adr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        rww_busy,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    FILL  = 3'd2,
    ERASE = 3'd3,
    PROG  = 3'd4
  } state_t;

  localparam logic [15:0] ERASE_LOAD = 16'(ERASE_CYCLES - 1);
  localparam logic [15:0] PROG_LOAD  = 16'(PROG_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  page_q, page_d;
  logic        rww_q, rww_d;
  logic        rd_fetch_q, rd_fetch_d;
  logic        rd_lpm_q, rd_lpm_d;
  logic        byte_hi_q, byte_hi_d;
  logic        fetch_ok;

  // A fetch may overlap an erase/write only when the page being changed is RWW
  // and the fetch targets the NRWW section.
`ifdef FLASH_SEQ_RWW_EN
  assign fetch_ok = fetch_req && rww_q && (fetch_adr >= NRWW_START);
`else
  assign fetch_ok = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      page_q     <= '0;
      rww_q      <= 1'b0;
      rd_fetch_q <= 1'b0;
      rd_lpm_q   <= 1'b0;
      byte_hi_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      page_q     <= page_d;
      rww_q      <= rww_d;
      rd_fetch_q <= rd_fetch_d;
      rd_lpm_q   <= rd_lpm_d;
      byte_hi_q  <= byte_hi_d;
    end
  end

  // Handshake: a requester holds req (with its address/data) until it sees gnt
  // in the same cycle; gnt is combinational, a dropped req is simply forgotten,
  // and the read result arrives as a one-cycle valid strobe the cycle after gnt.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    page_d     = page_q;
    rww_d      = rww_q;
    rd_fetch_d = 1'b0;
    rd_lpm_d   = 1'b0;
    byte_hi_d  = byte_hi_q;
    fetch_gnt  = 1'b0;
    lpm_gnt    = 1'b0;
    spm_gnt    = 1'b0;
    mem_rd     = 1'b0;
    mem_fill   = 1'b0;
    mem_erase  = 1'b0;
    mem_prog   = 1'b0;
    mem_adr    = '0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        if (nrst) begin
          if (spm_req) begin
            spm_gnt = 1'b1;
            page_d  = spm_adr[14:7];
            rww_d   = ({spm_adr[14:7], 6'b0} < NRWW_START);
            case (spm_op)
              2'b00: begin
                mem_fill  = 1'b1;
                mem_adr   = spm_adr;
                mem_wdata = spm_data;
                state_d   = FILL;
              end
              2'b01: begin
                mem_adr = {spm_adr[14:7], 7'b0};
                cnt_d   = ERASE_LOAD;
                state_d = ERASE;
              end
              2'b10: begin
                mem_adr = {spm_adr[14:7], 7'b0};
                cnt_d   = PROG_LOAD;
                state_d = PROG;
              end
              default: state_d = FILL;
            endcase
          end else if (lpm_req) begin
            lpm_gnt   = 1'b1;
            mem_rd    = 1'b1;
            mem_adr   = {lpm_adr[14:1], 1'b0};
            rd_lpm_d  = 1'b1;
            byte_hi_d = lpm_adr[0];
            state_d   = READ;
          end else if (fetch_req) begin
            fetch_gnt  = 1'b1;
            mem_rd     = 1'b1;
            mem_adr    = {fetch_adr, 1'b0};
            rd_fetch_d = 1'b1;
            state_d    = READ;
          end
        end
      end
      READ: state_d = IDLE;
      // FILL is the single completion cycle shared by fill, reserved op and erase/write.
      FILL: state_d = IDLE;
      ERASE, PROG: begin
        mem_erase = (state_q == ERASE);
        mem_prog  = (state_q == PROG);
        mem_adr   = {page_q, 7'b0};
        if (fetch_ok) begin
          fetch_gnt  = 1'b1;
          mem_rd     = 1'b1;
          mem_adr    = {fetch_adr, 1'b0};
          rd_fetch_d = 1'b1;
        end
        if (cnt_q == 16'd0) begin
          state_d = FILL;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fetch_valid = rd_fetch_q;
  assign fetch_data  = rd_fetch_q ? mem_rdata : 16'h0000;
  assign lpm_valid   = rd_lpm_q;
  assign lpm_data    = rd_lpm_q ? (byte_hi_q ? mem_rdata[15:8] : mem_rdata[7:0]) : 8'h00;
  assign spm_done    = (state_q == FILL);
  assign rww_busy    = ((state_q == ERASE) || (state_q == PROG)) && rww_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_flash_access_sequencer.sv
// Self-checking bench for flash_access_sequencer: array model, read scoreboards, SPM sequences and reset abort.
module tb_flash_access_sequencer;

  localparam int OP_CYCLES = 16;
`ifdef FLASH_SEQ_RWW_EN
  localparam int RWW_GNTS = OP_CYCLES;
`else
  localparam int RWW_GNTS = 0;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic        fetch_req;
  logic [13:0] fetch_adr;
  logic        fetch_gnt, fetch_valid;
  logic [15:0] fetch_data;
  logic        lpm_req;
  logic [14:0] lpm_adr;
  logic        lpm_gnt, lpm_valid;
  logic [7:0]  lpm_data;
  logic        spm_req;
  logic [1:0]  spm_op;
  logic [14:0] spm_adr;
  logic [15:0] spm_data;
  logic        spm_gnt, spm_done;
  logic        mem_rd, mem_fill, mem_erase, mem_prog;
  logic [14:0] mem_adr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;
  logic        rww_busy;
  logic [2:0]  state_dbg;

  logic [15:0] mem [16384];
  logic [15:0] exp_q[$];
  logic [7:0]  lpm_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  flash_access_sequencer dut (
    .clk(clk), .nrst(nrst),
    .fetch_req(fetch_req), .fetch_adr(fetch_adr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .lpm_req(lpm_req), .lpm_adr(lpm_adr), .lpm_gnt(lpm_gnt),
    .lpm_valid(lpm_valid), .lpm_data(lpm_data),
    .spm_req(spm_req), .spm_op(spm_op), .spm_adr(spm_adr), .spm_data(spm_data),
    .spm_gnt(spm_gnt), .spm_done(spm_done),
    .mem_rd(mem_rd), .mem_fill(mem_fill), .mem_erase(mem_erase), .mem_prog(mem_prog),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rww_busy(rww_busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", n_checks);
    $fatal(1, "watchdog");
  end

  // array model: registered read, data valid the cycle after mem_rd
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_adr[14:1]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // scoreboard: pop expected read data when the DUT strobes valid
  always @(negedge clk) begin
    if (fetch_valid === 1'b1) begin
      if (exp_q.size() == 0) check("fetch_spurious", 1, 0);
      else check("fetch_data", fetch_data, exp_q.pop_front());
    end
    if (lpm_valid === 1'b1) begin
      if (lpm_q.size() == 0) check("lpm_spurious", 1, 0);
      else check("lpm_data", lpm_data, lpm_q.pop_front());
    end
  end

  // drivers
  task automatic do_fetch(input logic [13:0] a);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    fetch_req = 1'b1; fetch_adr = a;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (fetch_gnt) begin
        got = 1'b1;
        exp_q.push_back(mem[a]);
        check("fetch_adr", mem_adr, {a, 1'b0});
      end
      @(posedge clk); #1;
    end
    fetch_req = 1'b0;
    check("fetch_gnt_wait", got, 1);
    @(negedge clk);
    check("fetch_latency", fetch_valid, 1);
  endtask

  task automatic do_lpm(input logic [14:0] a);
    bit got;
    logic [15:0] w;
    got = 1'b0;
    w = mem[a[14:1]];
    @(posedge clk); #1;
    lpm_req = 1'b1; lpm_adr = a;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (lpm_gnt) begin
        got = 1'b1;
        lpm_q.push_back(a[0] ? w[15:8] : w[7:0]);
        check("lpm_adr", mem_adr, {a[14:1], 1'b0});
      end
      @(posedge clk); #1;
    end
    lpm_req = 1'b0;
    check("lpm_gnt_wait", got, 1);
    @(negedge clk);
    check("lpm_latency", lpm_valid, 1);
  endtask

  // Erase/write with a fetch probe held throughout and competing lpm/spm requests
  // asserted then dropped during the first five strobe cycles.
  task automatic run_spm(input logic [1:0] op, input logic [14:0] adr, input logic [13:0] probe,
                         input int exp_gnts, input bit exp_busy);
    int strobe_cnt, busy_cnt, done_cnt, done_cyc, last_strobe, rd_gnts, other_gnts, adr_bad, kind_bad, cyc;
    bit after_gnt;
    strobe_cnt = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1; last_strobe = -1;
    rd_gnts = 0; other_gnts = 0; adr_bad = 0; kind_bad = 0; cyc = 0; after_gnt = 1'b0;
    @(posedge clk); #1;
    spm_req = 1'b1; spm_op = op; spm_adr = adr; spm_data = 16'h0000;
    @(negedge clk);
    check("spm_gnt", spm_gnt, 1);
    @(posedge clk); #1;
    spm_op = 2'b11; lpm_req = 1'b1; lpm_adr = 15'h0083;
    fetch_req = 1'b1; fetch_adr = probe;
    while (cyc < 80 && !after_gnt) begin
      @(negedge clk);
      cyc++;
      if (mem_erase || mem_prog) begin
        strobe_cnt++;
        last_strobe = cyc;
        if (rww_busy) busy_cnt++;
        if (fetch_gnt) rd_gnts++;
        if (!mem_rd && mem_adr != {adr[14:7], 7'b0}) adr_bad++;
        if (mem_erase != (op == 2'b01) || mem_prog != (op == 2'b10)) kind_bad++;
      end
      if (spm_done) begin done_cnt++; done_cyc = cyc; end
      if (lpm_gnt || spm_gnt) other_gnts++;
      if (fetch_gnt) exp_q.push_back(mem[probe]);
      if (fetch_gnt && done_cyc > 0) after_gnt = 1'b1;
      @(posedge clk); #1;
      if (cyc == 5) begin spm_req = 1'b0; lpm_req = 1'b0; end
    end
    fetch_req = 1'b0;
    check("spm_timeout", after_gnt, 1);
    check("strobe_cycles", strobe_cnt, OP_CYCLES);
    check("done_count", done_cnt, 1);
    check("done_timing", done_cyc, last_strobe + 1);
    check("rww_busy_cycles", busy_cnt, exp_busy ? OP_CYCLES : 0);
    check("fetch_during_op", rd_gnts, exp_gnts);
    check("no_lpm_spm_gnt", other_gnts, 0);
    check("page_adr", adr_bad, 0);
    check("strobe_kind", kind_bad, 0);
    @(negedge clk);
  endtask

  // stimulus
  initial begin
    bit got;
    int n;
    for (int i = 0; i < 16384; i++) mem[i] = 16'(i * 37) ^ 16'hC3A5;
    mem[14'h0041] = 16'h1234;
    mem[14'h3840] = 16'h6699;
    nrst = 1'b0; fetch_req = 1'b1; fetch_adr = 14'h0041; lpm_req = 1'b0; lpm_adr = '0;
    spm_req = 1'b1; spm_op = 2'b00; spm_adr = 15'h1234; spm_data = 16'hFFFF;

    #12;
    check("rst_fetch_gnt", fetch_gnt, 0);
    check("rst_spm_gnt", spm_gnt, 0);
    check("rst_mem_adr", mem_adr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_fetch_data", fetch_data, 0);
    check("rst_state", state_dbg, 0);
    fetch_req = 1'b0; spm_req = 1'b0;
    @(negedge clk); nrst = 1'b1;

    // single fetch: grant cycle N, data cycle N+1
    do_fetch(14'h0041);
    do_lpm(15'h0083);
    do_lpm(15'h0082);

    // lpm beats fetch; fetch follows once the read completes
    @(posedge clk); #1;
    lpm_req = 1'b1; lpm_adr = 15'h0083; fetch_req = 1'b1; fetch_adr = 14'h0041;
    @(negedge clk);
    check("arb_lpm_gnt", lpm_gnt, 1);
    check("arb_fetch_wait", fetch_gnt, 0);
    lpm_q.push_back(8'h12);
    @(posedge clk); #1;
    lpm_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (fetch_gnt) begin got = 1'b1; exp_q.push_back(16'h1234); end
      @(posedge clk); #1;
    end
    fetch_req = 1'b0;
    check("arb_fetch_later", got, 1);

    // spm beats everything; reserved op completes with no strobe; losers dropped
    @(posedge clk); #1;
    spm_req = 1'b1; spm_op = 2'b11; lpm_req = 1'b1; fetch_req = 1'b1;
    @(negedge clk);
    check("arb3_spm", spm_gnt, 1);
    check("arb3_lpm", lpm_gnt, 0);
    check("arb3_fetch", fetch_gnt, 0);
    check("rsv_strobes", {mem_rd, mem_fill, mem_erase, mem_prog}, 0);
    @(posedge clk); #1;
    spm_req = 1'b0; lpm_req = 1'b0; fetch_req = 1'b0;
    @(negedge clk);
    check("rsv_done", spm_done, 1);
    check("rsv_no_strobe", {mem_rd, mem_fill, mem_erase, mem_prog}, 0);
    @(negedge clk);
    check("rsv_done_once", spm_done, 0);
    check("dropped_no_gnt", {fetch_gnt, lpm_gnt, spm_gnt}, 0);

    // page buffer fill
    @(posedge clk); #1;
    spm_req = 1'b1; spm_op = 2'b00; spm_adr = 15'h0123; spm_data = 16'hBEEF;
    @(negedge clk);
    check("fill_gnt", spm_gnt, 1);
    check("fill_strobe", mem_fill, 1);
    check("fill_wdata", mem_wdata, 16'hBEEF);
    check("fill_adr", mem_adr, 15'h0123);
    @(posedge clk); #1;
    spm_req = 1'b0;
    @(negedge clk);
    check("fill_done", spm_done, 1);
    check("fill_pulse", mem_fill, 0);

    // erase/write: RWW vs NRWW targets and the section boundary
    run_spm(2'b01, 15'h0080, 14'h3840, RWW_GNTS, 1'b1);
    run_spm(2'b01, 15'h0080, 14'h0041, 0, 1'b1);
    run_spm(2'b10, 15'h7000, 14'h3840, 0, 1'b0);
    run_spm(2'b10, 15'h6F80, 14'h37FF, 0, 1'b1);
    run_spm(2'b01, 15'h6F80, 14'h3800, RWW_GNTS, 1'b1);

    // random reads
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) do_fetch(14'($urandom_range(0, 16383)));
      else do_lpm(15'($urandom_range(0, 32767)));
    end

    // reset in the fifth write cycle aborts the operation
    @(posedge clk); #1;
    spm_req = 1'b1; spm_op = 2'b10; spm_adr = 15'h7000;
    @(negedge clk);
    check("abort_gnt", spm_gnt, 1);
    @(posedge clk); #1;
    spm_req = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && n < 5; i++) begin
      @(negedge clk);
      if (mem_prog) n++;
    end
    check("abort_reached", n, 5);
    #2;
    nrst = 1'b0; fetch_req = 1'b1; fetch_adr = 14'h0041;
    #1;
    check("abort_prog_low", mem_prog, 0);
    check("abort_state", state_dbg, 0);
    check("abort_busy", rww_busy, 0);
    check("abort_mem_adr", mem_adr, 0);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (spm_done || fetch_gnt || mem_prog) n++;
    end
    check("abort_quiet_in_rst", n, 0);
    nrst = 1'b1;
    #1;
    check("gnt_after_rst", fetch_gnt, 1);
    exp_q.push_back(16'h1234);
    @(posedge clk); #1;
    fetch_req = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (spm_done || mem_prog) n++;
    end
    check("abort_no_done", n, 0);
    check("abort_idle", state_dbg, 0);

    // final report
    check("fetch_q_empty", exp_q.size(), 0);
    check("lpm_q_empty", lpm_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
